// File: rtl/dm_line_refill_if.sv
// Bus bundle between the line-refill engine, the cache (miss/fill side) and main memory.
// The master modport is the refill engine; slave is the surrounding cache/memory.
interface dm_line_refill_if #(
  parameter int unsigned ADDR_LEN  = 25,
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned LINE_SIZE = 1024,
  parameter int unsigned TAG_LEN   = 11,
  parameter int unsigned INDEX_LEN = 7
);
  logic                  miss_valid;
  logic [ADDR_LEN-1:0]   miss_addr;
  logic                  miss_ready;
  logic                  mem_req_valid;
  logic [ADDR_LEN-1:0]   mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [DATA_LEN-1:0]   mem_rsp_data;
  logic                  crit_valid;
  logic [DATA_LEN-1:0]   crit_data;
  logic                  fill_we;
  logic [INDEX_LEN-1:0]  fill_index;
  logic [TAG_LEN-1:0]    fill_tag;
  logic [LINE_SIZE-1:0]  fill_line;
  logic                  busy;

  modport master (
    input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output miss_ready, mem_req_valid, mem_req_addr, crit_valid, crit_data,
           fill_we, fill_index, fill_tag, fill_line, busy
  );

  modport slave (
    output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  miss_ready, mem_req_valid, mem_req_addr, crit_valid, crit_data,
           fill_we, fill_index, fill_tag, fill_line, busy
  );
endinterface

// File: rtl/dm_line_refill.sv
// Direct-mapped cache miss-refill engine: critical-word-first wrapping fetch of one
// line, early forwarding of the missed word, then a single-cycle line/tag write.
module dm_line_refill #(
  parameter int unsigned ADDR_LEN   = 25,
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned LINE_SIZE  = 1024,
  parameter int unsigned TAG_LEN    = 11,
  parameter int unsigned INDEX_LEN  = 7,
  parameter int unsigned OFFSET_LEN = 7
) (
  input  logic             clk,
  input  logic             rst,
  dm_line_refill_if.master bus
);
  localparam int unsigned WORDS  = LINE_SIZE / DATA_LEN;
  localparam int unsigned WORD_W = $clog2(WORDS);
  localparam int unsigned LSB_W  = $clog2(LINE_SIZE);
  localparam int unsigned BYTE_W = OFFSET_LEN - WORD_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t                state, state_n;
  logic [TAG_LEN-1:0]    tag_q;
  logic [INDEX_LEN-1:0]  index_q;
  logic [WORD_W-1:0]     start_q, beat_q, ptr;
  logic [LINE_SIZE-1:0]  line_q, line_n;
  logic [LSB_W-1:0]      word_lsb;
  logic                  latch, take, last_beat;
  logic [ADDR_LEN-1:0]   req_addr_n;

  assign ptr       = start_q + beat_q;
  assign word_lsb  = LSB_W'(ptr) * LSB_W'(DATA_LEN);
  assign last_beat = (beat_q == WORD_W'(WORDS - 1));

  // Next state plus the request address for the upcoming REQ
  always_comb begin
    state_n    = state;
    latch      = 1'b0;
    take       = 1'b0;
    req_addr_n = bus.mem_req_addr;
    unique case (state)
      IDLE: if (bus.miss_valid) begin
        latch      = 1'b1;
        state_n    = REQ;
        req_addr_n = {bus.miss_addr[ADDR_LEN-1:BYTE_W], BYTE_W'(0)};
      end
      REQ:  if (bus.mem_req_ready) state_n = WAIT;
      WAIT: if (bus.mem_rsp_valid) begin
        take       = 1'b1;
        state_n    = last_beat ? FILL : REQ;
        req_addr_n = {tag_q, index_q, WORD_W'(ptr + WORD_W'(1)), BYTE_W'(0)};
      end
      FILL: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Line buffer with the incoming beat merged in at its wrapped word position
  always_comb begin
    line_n = line_q;
    line_n[word_lsb +: DATA_LEN] = bus.mem_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (take) line_q <= line_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      tag_q             <= '0;
      index_q           <= '0;
      start_q           <= '0;
      beat_q            <= '0;
      bus.miss_ready    <= 1'b1;
      bus.busy          <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.crit_valid    <= 1'b0;
      bus.crit_data     <= '0;
      bus.fill_we       <= 1'b0;
      bus.fill_index    <= '0;
      bus.fill_tag      <= '0;
      bus.fill_line     <= '0;
    end else begin
      state             <= state_n;
      bus.miss_ready    <= (state_n == IDLE);
      bus.busy          <= (state_n != IDLE);
      bus.mem_req_valid <= (state_n == REQ);
      bus.mem_req_addr  <= req_addr_n;
      bus.crit_valid    <= take && (beat_q == '0);
      bus.fill_we       <= take && last_beat;
      if (latch) begin
        tag_q   <= bus.miss_addr[ADDR_LEN-1 -: TAG_LEN];
        index_q <= bus.miss_addr[OFFSET_LEN +: INDEX_LEN];
        start_q <= bus.miss_addr[BYTE_W +: WORD_W];
        beat_q  <= '0;
      end
      if (take && !last_beat) beat_q <= beat_q + WORD_W'(1);
      if (take && (beat_q == '0)) bus.crit_data <= bus.mem_rsp_data;
      if (take && last_beat) begin
        bus.fill_line  <= line_n;
        bus.fill_index <= index_q;
        bus.fill_tag   <= tag_q;
      end
    end
  end
endmodule

// File: tb/tb_dm_line_refill.sv
// Scoreboard bench for dm_line_refill: expectations are queued at miss issue,
// a negedge monitor and the memory model pop and compare as the DUT responds.
module tb_dm_line_refill;
  typedef struct {
    logic [6:0]    idx;
    logic [10:0]   tag;
    logic [1023:0] line;
  } fill_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_line_refill_if bus ();
  dm_line_refill dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  fill_t        fill_q[$];
  logic [31:0]  crit_q[$];
  logic [24:0]  req_q[$];
  logic [24:0]  req_log[$];

  logic [31:0]   salt = 32'h0;
  int            mode = 0;
  int            req_count = 0;
  int            fill_count = 0;
  logic [31:0]   last_crit = '0;
  logic [1023:0] last_line = '0;
  logic [10:0]   last_tag = '0;

  function automatic logic [31:0] mem_fn(input logic [24:0] a);
    return {7'b0, a} ^ salt;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_line(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int w = 0; w < 32; w++) begin
        if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
          $display("FAIL %s: word %0d got %h expected %h", name, w, act[w*32 +: 32], exp[w*32 +: 32]);
          break;
        end
      end
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected request order, critical word and assembled line for one miss
  task automatic push_miss(input logic [24:0] a);
    fill_t      e;
    logic [4:0] p;
    logic [24:0] wa;
    e.tag  = a[24:14];
    e.idx  = a[13:7];
    e.line = '0;
    for (int w = 0; w < 32; w++) begin
      p  = 5'(a[6:2] + 5'(w));
      wa = {a[24:14], a[13:7], p, 2'b00};
      req_q.push_back(wa);
      e.line[32*int'(p) +: 32] = mem_fn(wa);
    end
    crit_q.push_back(mem_fn({a[24:2], 2'b00}));
    fill_q.push_back(e);
  endtask

  task automatic issue_miss(input logic [24:0] a);
    bit ok = 0;
    push_miss(a);
    req_count = 0;
    req_log.delete();
    bus.miss_valid = 1'b1;
    bus.miss_addr  = a;
    for (int i = 0; i < 3000; i++) begin
      if (bus.miss_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    bus.miss_valid = 1'b0;
    if (!ok) note_fail("miss_accept_timeout");
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.busy && fill_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) note_fail("refill_timeout");
    check("req_q_drained", 64'(req_q.size()), 64'd0);
    check("crit_q_drained", 64'(crit_q.size()), 64'd0);
  endtask

  // Memory model with ready/response stalls; also checks request order and stability
  bit          pending = 0;
  bit          seen = 0;
  int          rsp_cnt = 0;
  int          rdy_cnt = 0;
  logic [24:0] pend_addr = '0;
  logic [24:0] seen_addr = '0;
  logic [24:0] exp_addr;

  always @(negedge clk) begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    if (pending) begin
      if (rsp_cnt == 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_fn(pend_addr);
        pending = 0;
      end else begin
        rsp_cnt--;
      end
    end
    if (!rst && bus.mem_req_valid && !pending) begin
      if (seen) begin
        check("req_addr_stable", 64'(bus.mem_req_addr), 64'(seen_addr));
      end else begin
        seen      = 1;
        seen_addr = bus.mem_req_addr;
        rdy_cnt   = (mode == 1) ? int'($urandom_range(0, 5)) : 0;
      end
      if (rdy_cnt == 0) begin
        bus.mem_req_ready = 1'b1;
        pending   = 1;
        pend_addr = bus.mem_req_addr;
        seen      = 0;
        req_count++;
        req_log.push_back(bus.mem_req_addr);
        rsp_cnt = (mode == 1) ? int'($urandom_range(0, 5)) : (mode == 2) ? 4 : 0;
        if (req_q.size() == 0) begin
          note_fail("req_unexpected");
        end else begin
          exp_addr = req_q.pop_front();
          check("req_addr", 64'(bus.mem_req_addr), 64'(exp_addr));
        end
      end else begin
        rdy_cnt--;
      end
    end
  end

  // Output monitor: critical-word pulses and line writes
  fill_t fe;
  logic [31:0] ce;
  always @(negedge clk) begin
    if (bus.crit_valid) begin
      if (crit_q.size() == 0) begin
        note_fail("crit_unexpected");
      end else begin
        ce = crit_q.pop_front();
        check("crit_data", 64'(bus.crit_data), 64'(ce));
      end
      last_crit = bus.crit_data;
    end
    if (bus.fill_we) begin
      fill_count++;
      if (fill_q.size() == 0) begin
        note_fail("fill_unexpected");
      end else begin
        fe = fill_q.pop_front();
        check("fill_index", 64'(bus.fill_index), 64'(fe.idx));
        check("fill_tag", 64'(bus.fill_tag), 64'(fe.tag));
        check_line("fill_line", bus.fill_line, fe.line);
      end
      last_line = bus.fill_line;
      last_tag  = bus.fill_tag;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miss_ready"}, 64'(bus.miss_ready), 64'd1);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check({tag, "_crit_valid"}, 64'(bus.crit_valid), 64'd0);
    check({tag, "_fill_we"}, 64'(bus.fill_we), 64'd0);
  endtask

  logic [24:0] addrs[3] = '{25'h0ABCDE4, 25'h1234568, 25'h155557C};
  bit got;
  int fc;

  initial begin
    rst = 1'b1;
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values, then 10 idle cycles
    check_reset_outputs("reset");
    check("reset_req_addr", 64'(bus.mem_req_addr), 64'd0);
    check("reset_crit_data", 64'(bus.crit_data), 64'd0);
    check("reset_fill_index", 64'(bus.fill_index), 64'd0);
    check("reset_fill_tag", 64'(bus.fill_tag), 64'd0);
    check_line("reset_fill_line", bus.fill_line, '0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_miss_ready", 64'(bus.miss_ready), 64'd1);
      check("idle_busy", 64'(bus.busy), 64'd0);
    end

    // Start-0 line, no stalls, data = address
    issue_miss(25'h0000080);
    wait_idle();
    check("t1_req_count", 64'(req_count), 64'd32);
    check("t1_first_req", 64'(req_log[0]), 64'h80);
    check("t1_last_req", 64'(req_log[31]), 64'hFC);
    check("t1_crit", 64'(last_crit), 64'h80);
    check("t1_word31", 64'(last_line[1023:992]), 64'hFC);
    check("t1_fill_count", 64'(fill_count), 64'd1);
    repeat (5) @(negedge clk);
    check_line("t1_fill_line_hold", bus.fill_line, last_line);

    // Start-31 wrap at the top of the address space
    issue_miss(25'h1FFFFFC);
    wait_idle();
    check("t2_first_req", 64'(req_log[0]), 64'h1FFFFFC);
    check("t2_second_req", 64'(req_log[1]), 64'h1FFFF80);
    check("t2_fill_tag", 64'(last_tag), 64'h7FF);
    check("t2_word31_is_crit", 64'(last_line[1023:992]), 64'(last_crit));
    check("t2_crit", 64'(last_crit), 64'h1FFFFFC);

    // Random ready/response stalls
    mode = 1;
    salt = 32'hA5A5_0000;
    foreach (addrs[k]) begin
      issue_miss(addrs[k]);
      wait_idle();
      check("t3_req_count", 64'(req_count), 64'd32);
    end

    // Reset abort while waiting on beat 10
    mode = 2;
    salt = 32'h0F0F_0F0F;
    fc = fill_count;
    push_miss(25'h0C0FFEC);
    req_count = 0;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 25'h0C0FFEC;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      if (req_count == 11) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) note_fail("abort_beat10_timeout");
    @(negedge clk);
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    req_q.delete();
    fill_q.delete();
    crit_q.delete();
    repeat (10) @(negedge clk);
    check("abort_still_idle", 64'(bus.busy), 64'd0);
    check("abort_no_fill", 64'(fill_count), 64'(fc));

    mode = 0;
    issue_miss(25'h0C0FFEC);
    wait_idle();
    check("abort_fresh_fill", 64'(fill_count), 64'(fc + 1));

    // miss_valid held through a refill, then back-to-back second miss
    salt = 32'h1357_9BDF;
    fc = fill_count;
    push_miss(25'h0400100);
    req_count = 0;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 25'h0400100;
    @(negedge clk);
    push_miss(25'h0800248);
    bus.miss_addr = 25'h0800248;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.fill_we) begin
        got = 1;
        break;
      end
    end
    if (!got) note_fail("b2b_fill_timeout");
    check("b2b_ready_in_fill", 64'(bus.miss_ready), 64'd0);
    @(negedge clk);
    check("b2b_idle_after_fill", 64'(bus.miss_ready), 64'd1);
    check("b2b_busy_after_fill", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.miss_valid = 1'b0;
    check("b2b_second_accept", 64'(bus.busy), 64'd1);
    check("b2b_second_req", 64'(bus.mem_req_valid), 64'd1);
    wait_idle();
    check("b2b_fill_count", 64'(fill_count), 64'(fc + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
